audio_frame_buffer: RTL and testbench
=====================================

AUDIO_FRAME_BUFFER -- requirements
Module: audio_frame_buffer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16: signed sample width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 1024: samples per frame; a power of two, 4 or more.
REQ-003 SHALL have parameter NUM_CH, default 2: codec channels; a power of two, 1 or more.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- cfg_mix_i  in  1  1 = average all channels; 0 = single channel.
- cfg_ch_i  in  max(1,clog2(NUM_CH))  channel selected when cfg_mix_i=0.
- smp_valid_i  in  1  one-cycle sample strobe.
- smp_ch_i  in  max(1,clog2(NUM_CH))  channel index of the strobed sample.
- smp_data_i  in  SAMPLE_W  signed sample.
- frame_start_o  out  1  one-cycle pulse when a new frame is handed to the consumer.
- frame_ready_o  out  1  level: the read bank holds a valid frame.
- rd_addr_i  in  clog2(FRAME_LEN)  consumer read address.
- rd_data_o  out  SAMPLE_W  read data.
- frame_done_i  in  1  consumer releases the read bank.
- overflow_o  out  1  sticky: samples were dropped.

Function
REQ-005 SHALL hold two banks of FRAME_LEN samples each: one write bank and one read bank.
REQ-006 SHALL register rd_data_o so it equals bank[rd_addr_i] exactly 1 cycle after rd_addr_i is applied; data is undefined while frame_ready_o=0.
REQ-007 In single-channel mode, SHALL write each sample with smp_valid_i=1 and smp_ch_i=latched channel, at write pointer wp, then increment wp.
REQ-008 In mix mode, SHALL accumulate the samples for channels 0..NUM_CH-1 in a SAMPLE_W+clog2(NUM_CH) bit signed accumulator.
REQ-009 On the channel NUM_CH-1 sample, SHALL write the accumulator arithmetically shifted right by clog2(NUM_CH), truncated toward minus infinity.
REQ-010 A channel-0 sample SHALL restart the accumulator; an out-of-order channel SHALL set a dropped-group flag, so that no write occurs for that group.
REQ-011 SHALL latch cfg_mix_i and cfg_ch_i only when wp=0 and no accumulation is in progress; mid-frame changes take effect at the next frame.
REQ-012 SHALL implement write FSM states FILL and HOLD:
- FILL: when wp wraps from FRAME_LEN-1 to 0 and frame_ready_o=0, or frame_done_i=1 in the same cycle, swap the banks, set frame_ready_o=1, pulse frame_start_o, and stay in FILL.
- FILL: otherwise go to HOLD.
- HOLD: discard every strobed sample and set overflow_o=1 for each one.
- HOLD: on frame_done_i, swap the banks, pulse frame_start_o, keep frame_ready_o=1, and go to FILL with wp=0.
REQ-013 frame_done_i in FILL with no simultaneous wrap SHALL clear frame_ready_o on the next cycle; frame_done_i while frame_ready_o=0 SHALL be ignored.
REQ-014 A swap SHALL occur at most once per cycle; frame_start_o SHALL never be high on two consecutive cycles.
REQ-015 SHALL never write the read bank while frame_ready_o=1.

Reset
REQ-016 While rst=1 at a clk edge, the block SHALL go to state FILL with the following outputs and state:
- wp=0, accumulator=0, write bank=0.
- frame_start_o=0, frame_ready_o=0, overflow_o=0, rd_data_o=0.
- cfg latched from inputs.
REQ-017 Reset mid-frame SHALL discard partial data; RAM contents need not be cleared.

Configuration
REQ-018 Macro AUDIO_FRAME_BUFFER_OVF_CNT_EN:
- Defined: adds output ovf_cnt_o, 16 bits, saturating at 0xFFFF, incremented for each dropped sample, cleared by rst.
- Undefined: the port and counter are absent; overflow_o is unchanged.

Structure
REQ-019 Package afb_pkg SHALL hold the FSM state enum (FILL, HOLD) and the default parameter constants.
REQ-020 SHALL instantiate one sub-module afb_sdp_ram: simple dual-port RAM, 2*FRAME_LEN x SAMPLE_W, registered read. Bank select is the address MSB.

Verification
REQ-021 FRAME_LEN=8, NUM_CH=2, cfg_mix_i=0, cfg_ch_i=1; feed ch0=100, ch1=k for k=0..7 -> frame_start_o pulse after the 8th ch1 sample; reading addr 0..7 yields 0..7.
REQ-022 cfg_mix_i=1; pairs (3,4) and (-3,-4) -> stored 3 and -4.
REQ-023 Hold frame_done_i low across two full frames, then feed 5 more samples -> overflow_o=1 and ovf_cnt_o=5 (macro defined); assert frame_done_i -> frame_start_o pulses next cycle and the second frame is readable.
REQ-024 Assert frame_done_i in the same cycle as the 8th write -> single frame_start_o pulse and frame_ready_o stays 1.
REQ-025 Assert rst after 5 samples -> all outputs 0; next frame begins at wp=0.
REQ-026 Change cfg_ch_i mid-frame -> the current frame keeps the old channel and the next frame uses the new one.

Source files
------------

// File: rtl/afb_pkg.sv
// Shared types and default sizing for the audio frame buffer.
package afb_pkg;

  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_FRAME_LEN = 1024;
  localparam int DEF_NUM_CH    = 2;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } afb_state_e;

endpackage

// File: rtl/afb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module afb_sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_frame_buffer.sv
// Ping-pong frame buffer for codec samples, single-channel or channel-averaged.
// Optional macro AUDIO_FRAME_BUFFER_OVF_CNT_EN adds a saturating dropped-sample counter.
module audio_frame_buffer
  import afb_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int NUM_CH    = DEF_NUM_CH,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW       = $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_mix_i,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic                smp_valid_i,
  input  logic [CH_W-1:0]     smp_ch_i,
  input  logic [SAMPLE_W-1:0] smp_data_i,
  output logic                frame_start_o,
  output logic                frame_ready_o,
  input  logic [AW-1:0]       rd_addr_i,
  output logic [SAMPLE_W-1:0] rd_data_o,
  input  logic                frame_done_i,
  output logic                overflow_o
`ifdef AUDIO_FRAME_BUFFER_OVF_CNT_EN
  ,
  output logic [15:0]         ovf_cnt_o
`endif
);

  localparam int CH_LOG = $clog2(NUM_CH);
  localparam int ACC_W  = SAMPLE_W + CH_LOG;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [AW-1:0]   WP_LAST = AW'(FRAME_LEN - 1);

  afb_state_e state, state_nxt;
  logic [AW-1:0]           wp;
  logic                    wbank;
  logic                    mix_q;
  logic [CH_W-1:0]         ch_q;
  logic signed [ACC_W-1:0] acc;
  logic                    grp_ok;
  logic [CH_W-1:0]         exp_ch;

  logic                    cfg_live, mix_eff;
  logic [CH_W-1:0]         ch_eff;
  logic signed [ACC_W-1:0] smp_ext, sum;
  logic                    first, last, in_order;
  logic                    wr_evt, we, wrap, drop, swap, ready_nxt;
  logic [SAMPLE_W-1:0]     wdata;

  // Configuration is transparent at a frame boundary so the first sample of a frame sees it.
  always_comb begin
    cfg_live = (wp == '0) && !grp_ok;
    mix_eff  = cfg_live ? cfg_mix_i : mix_q;
    ch_eff   = cfg_live ? cfg_ch_i  : ch_q;
    smp_ext  = ACC_W'($signed(smp_data_i));
    first    = (smp_ch_i == '0);
    last     = (smp_ch_i == LAST_CH);
    in_order = first || (grp_ok && (smp_ch_i == exp_ch));
    sum      = first ? smp_ext : (acc + smp_ext);
    wdata    = mix_eff ? SAMPLE_W'(sum >>> CH_LOG) : smp_data_i;
    wr_evt   = smp_valid_i && (mix_eff ? (in_order && last) : (smp_ch_i == ch_eff));
    we       = (state == FILL) && wr_evt;
    wrap     = we && (wp == WP_LAST);
    drop     = smp_valid_i && (state == HOLD);
  end

  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    ready_nxt = frame_ready_o;
    case (state)
      FILL: begin
        if (wrap) begin
          if (!frame_ready_o || frame_done_i) begin
            swap      = 1'b1;
            ready_nxt = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end else if (frame_done_i) begin
          ready_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (frame_done_i) begin
          swap      = 1'b1;
          state_nxt = FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      wp            <= '0;
      wbank         <= 1'b0;
      acc           <= '0;
      grp_ok        <= 1'b0;
      exp_ch        <= '0;
      mix_q         <= cfg_mix_i;
      ch_q          <= cfg_ch_i;
      frame_start_o <= 1'b0;
      frame_ready_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_start_o <= swap;
      frame_ready_o <= ready_nxt;
      if (swap) wbank <= ~wbank;
      if (drop) overflow_o <= 1'b1;
      if (cfg_live) begin
        mix_q <= cfg_mix_i;
        ch_q  <= cfg_ch_i;
      end
      if (we) wp <= wp + AW'(1);
      // An out-of-order channel kills the group; only a channel-0 sample starts a new one.
      if ((state == FILL) && smp_valid_i && mix_eff) begin
        if (in_order && !last) begin
          acc    <= sum;
          grp_ok <= 1'b1;
          exp_ch <= smp_ch_i + CH_W'(1);
        end else begin
          grp_ok <= 1'b0;
        end
      end
    end
  end

`ifdef AUDIO_FRAME_BUFFER_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                               ovf_cnt_o <= '0;
    else if (drop && (ovf_cnt_o != 16'hFFFF)) ovf_cnt_o <= ovf_cnt_o + 16'd1;
  end
`endif

  afb_sdp_ram #(
    .DATA_W(SAMPLE_W),
    .ADDR_W(AW + 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr ({wbank, wp}),
    .wdata (wdata),
    .raddr ({~wbank, rd_addr_i}),
    .rdata (rd_data_o)
  );

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Self-checking bench for audio_frame_buffer (FRAME_LEN=8, NUM_CH=2).
module tb_audio_frame_buffer;

  localparam int FL = 8;
  localparam int NC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_mix;
  logic [0:0]  cfg_ch;
  logic        smp_valid;
  logic [0:0]  smp_ch;
  logic [15:0] smp_data;
  logic        frame_start;
  logic        frame_ready;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        frame_done;
  logic        overflow;
`ifdef AUDIO_FRAME_BUFFER_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  audio_frame_buffer #(.SAMPLE_W(16), .FRAME_LEN(FL), .NUM_CH(NC)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_mix_i     (cfg_mix),
    .cfg_ch_i      (cfg_ch),
    .smp_valid_i   (smp_valid),
    .smp_ch_i      (smp_ch),
    .smp_data_i    (smp_data),
    .frame_start_o (frame_start),
    .frame_ready_o (frame_ready),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .frame_done_i  (frame_done),
    .overflow_o    (overflow)
`ifdef AUDIO_FRAME_BUFFER_OVF_CNT_EN
    ,
    .ovf_cnt_o     (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_f [FL];

  typedef struct {
    int a;
    int b;
    int avg;
  } mix_vec_t;
  mix_vec_t tv [FL];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input int d);
    smp_valid = 1'b1;
    smp_ch    = ch[0];
    smp_data  = d[15:0];
    step();
    smp_valid = 1'b0;
  endtask

  task automatic read_frame(input string tag);
    for (int i = 0; i < FL; i++) begin
      rd_addr = 3'(i);
      step();
      chk($sformatf("%s[%0d]", tag, i), $signed(rd_data), exp_f[i]);
    end
  endtask

  task automatic release_bank();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  // Reference model: frames as queues, mix average as floor division.
  int m_fill[$];
  int m_grp[$];
  int m_held[$];
  int m_rd [FL];
  bit m_ready, m_hold, m_ovf, m_start, m_mix;
  int m_ch, m_cnt;

  function automatic int floor_avg(input int s);
    if (s >= 0) return s / NC;
    return -((-s + NC - 1) / NC);
  endfunction

  task automatic model_step(input bit v, input int ch, input int d, input bit done);
    bit complete;
    m_start  = 1'b0;
    complete = 1'b0;
    if (m_fill.size() == 0 && m_grp.size() == 0) begin
      m_mix = cfg_mix;
      m_ch  = int'(cfg_ch);
    end
    if (m_hold) begin
      if (v) begin
        m_ovf = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
      if (done) begin
        for (int i = 0; i < FL; i++) m_rd[i] = m_held[i];
        m_hold  = 1'b0;
        m_start = 1'b1;
      end
    end else begin
      if (v) begin
        if (!m_mix) begin
          if (ch == m_ch) m_fill.push_back(d);
        end else begin
          if (ch == 0) begin
            m_grp.delete();
            m_grp.push_back(d);
          end else if (m_grp.size() != 0 && ch == m_grp.size()) begin
            m_grp.push_back(d);
          end else begin
            m_grp.delete();
          end
          if (m_grp.size() == NC) begin
            int s = 0;
            foreach (m_grp[i]) s += m_grp[i];
            m_fill.push_back(floor_avg(s));
            m_grp.delete();
          end
        end
        complete = (m_fill.size() == FL);
      end
      if (complete) begin
        if (!m_ready || done) begin
          for (int i = 0; i < FL; i++) m_rd[i] = m_fill[i];
          m_ready = 1'b1;
          m_start = 1'b1;
        end else begin
          m_held = m_fill;
          m_hold = 1'b1;
        end
        m_fill.delete();
      end else if (done) begin
        m_ready = 1'b0;
      end
    end
  endtask

  initial begin
    int next_ch, ch_r, data_r;
    bit rd_ok;
    int rd_exp;

    rst = 1'b1; cfg_mix = 1'b0; cfg_ch = 1'b1; smp_valid = 1'b0; smp_ch = 1'b0;
    smp_data = '0; rd_addr = '0; frame_done = 1'b0;
    step();
    chk("rst_start", frame_start, 0);
    chk("rst_ready", frame_ready, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rd", rd_data, 0);
`ifdef AUDIO_FRAME_BUFFER_OVF_CNT_EN
    chk("rst_ovf_cnt", ovf_cnt, 0);
`endif
    rst = 1'b0;

    // Single channel 1, ch0 samples ignored.
    for (int k = 0; k < FL; k++) begin
      put(0, 100);
      put(1, k);
    end
    chk("s1_start", frame_start, 1);
    chk("s1_ready", frame_ready, 1);
    step();
    chk("s1_start_clr", frame_start, 0);
    for (int i = 0; i < FL; i++) exp_f[i] = i;
    read_frame("s1");

    // Table of mix-mode pairs with floor-average results.
    tv[0] = '{3, 4, 3};          tv[1] = '{-3, -4, -4};
    tv[2] = '{-1, 0, -1};        tv[3] = '{32767, 32767, 32767};
    tv[4] = '{-32768, -32768, -32768}; tv[5] = '{1, 0, 0};
    tv[6] = '{-32768, 32767, -1}; tv[7] = '{5, -6, -1};
    cfg_mix = 1'b1;
    release_bank();
    chk("mix_rel_ready", frame_ready, 0);
    for (int i = 0; i < FL; i++) begin
      put(0, tv[i].a);
      put(1, tv[i].b);
      exp_f[i] = tv[i].avg;
    end
    chk("mix_start", frame_start, 1);
    read_frame("mix");

    // Two frames without release, then overflow in HOLD.
    cfg_mix = 1'b0;
    release_bank();
    for (int i = 0; i < FL; i++) put(1, 10 + i);
    chk("fa_start", frame_start, 1);
    for (int i = 0; i < FL; i++) put(1, 20 + i);
    chk("fb_start", frame_start, 0);
    chk("fb_ready", frame_ready, 1);
    chk("fb_ovf0", overflow, 0);
    for (int i = 0; i < 5; i++) put(i % 2, 99);
    chk("hold_ovf", overflow, 1);
`ifdef AUDIO_FRAME_BUFFER_OVF_CNT_EN
    chk("hold_ovf_cnt", ovf_cnt, 5);
`endif
    release_bank();
    chk("hold_rel_start", frame_start, 1);
    chk("hold_rel_ready", frame_ready, 1);
    step();
    chk("hold_rel_start_clr", frame_start, 0);
    for (int i = 0; i < FL; i++) exp_f[i] = 20 + i;
    read_frame("fb");

    // Release in the same cycle as the last write of a frame.
    for (int i = 0; i < FL - 1; i++) put(1, 30 + i);
    frame_done = 1'b1;
    put(1, 37);
    frame_done = 1'b0;
    chk("coinc_start", frame_start, 1);
    chk("coinc_ready", frame_ready, 1);
    step();
    chk("coinc_start_clr", frame_start, 0);
    chk("coinc_ready_hold", frame_ready, 1);
    for (int i = 0; i < FL; i++) exp_f[i] = 30 + i;
    read_frame("fc");

    // Channel change mid-frame applies from the next frame.
    release_bank();
    chk("cfg_rel_ready", frame_ready, 0);
    cfg_ch = 1'b1;
    for (int i = 0; i < FL; i++) begin
      if (i == 4) cfg_ch = 1'b0;
      put(0, 200 + i);
      put(1, 300 + i);
    end
    chk("cfg_d_start", frame_start, 1);
    for (int i = 0; i < FL; i++) begin
      put(0, 400 + i);
      put(1, 500 + i);
    end
    chk("cfg_e_start", frame_start, 0);
    for (int i = 0; i < FL; i++) exp_f[i] = 300 + i;
    read_frame("fd");
    release_bank();
    chk("cfg_e_rel_start", frame_start, 1);
    for (int i = 0; i < FL; i++) exp_f[i] = 400 + i;
    read_frame("fe");

    // Reset mid-frame.
    for (int i = 0; i < 5; i++) put(0, 1);
    rst = 1'b1;
    step();
    chk("mrst_start", frame_start, 0);
    chk("mrst_ready", frame_ready, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_rd", rd_data, 0);
`ifdef AUDIO_FRAME_BUFFER_OVF_CNT_EN
    chk("mrst_ovf_cnt", ovf_cnt, 0);
`endif
    rst = 1'b0;
    for (int i = 0; i < FL - 1; i++) put(0, 600 + i);
    chk("mrst_no_early", frame_start, 0);
    put(0, 607);
    chk("mrst_start2", frame_start, 1);
    for (int i = 0; i < FL; i++) exp_f[i] = 600 + i;
    read_frame("fr");

    // Randomized traffic against the reference model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_fill.delete(); m_grp.delete(); m_held.delete();
    for (int i = 0; i < FL; i++) m_rd[i] = 0;
    m_ready = 0; m_hold = 0; m_ovf = 0; m_start = 0; m_cnt = 0;
    m_mix = cfg_mix; m_ch = int'(cfg_ch);
    next_ch = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        cfg_mix = 1'($urandom_range(0, 1));
        cfg_ch  = 1'($urandom_range(0, 1));
      end
      smp_valid = ($urandom_range(0, 2) != 0);
      ch_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : next_ch;
      if (smp_valid) next_ch = ch_r ^ 1;
      data_r = int'($urandom_range(0, 65535)) - 32768;
      smp_ch = ch_r[0];
      smp_data = data_r[15:0];
      frame_done = ($urandom_range(0, 11) == 0);
      rd_addr = 3'($urandom_range(0, 7));
      rd_ok  = m_ready;
      rd_exp = m_rd[rd_addr];
      model_step(smp_valid, ch_r, data_r, frame_done);
      step();
      chk("rnd_start", frame_start, m_start);
      chk("rnd_ready", frame_ready, m_ready);
      chk("rnd_ovf", overflow, m_ovf);
      if (rd_ok) chk("rnd_rd", $signed(rd_data), rd_exp);
`ifdef AUDIO_FRAME_BUFFER_OVF_CNT_EN
      chk("rnd_ovf_cnt", ovf_cnt, m_cnt);
`endif
    end
    smp_valid = 1'b0;
    frame_done = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
